// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and width limits for the nibble-serial ALU.
package alu_pkg;

    localparam int unsigned MIN_WIDTH = 8;
    localparam int unsigned MAX_WIDTH = 32;
    localparam int unsigned OP_W      = 4;
    localparam int unsigned SLICE_W   = 4;

    localparam logic [OP_W-1:0] OP_ADD = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB = 4'd1;
    localparam logic [OP_W-1:0] OP_AND = 4'd2;
    localparam logic [OP_W-1:0] OP_OR  = 4'd3;
    localparam logic [OP_W-1:0] OP_XOR = 4'd4;
    localparam logic [OP_W-1:0] OP_SHL = 4'd5;
    localparam logic [OP_W-1:0] OP_SHR = 4'd6;
    localparam logic [OP_W-1:0] OP_NOT = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Opcodes 8..15 are unsupported.
    function automatic logic op_is_bad(input logic [OP_W-1:0] op);
        return op[3];
    endfunction

    // Opcodes whose final link bit is reported on n_carry_out.
    function automatic logic op_has_link(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SHL) || (op == OP_SHR);
    endfunction

endpackage

// File: rtl/alu_nibble.sv
// One 4-bit ALU slice; link carries the carry (ADD/SUB/SHL) or shift bit (SHR).
module alu_nibble
    import alu_pkg::*;
(
    input  logic [SLICE_W-1:0] a4,
    input  logic [SLICE_W-1:0] b4,
    input  logic [OP_W-1:0]    op,
    input  logic               link_in,
    output logic [SLICE_W-1:0] r4,
    output logic               link_out
);

    logic [SLICE_W:0] sum_c;

    // Slice datapath, selected by opcode.
    always_comb begin
        sum_c    = '0;
        r4       = '0;
        link_out = 1'b0;
        unique case (op)
            OP_ADD: begin
                sum_c    = {1'b0, a4} + {1'b0, b4} + (SLICE_W+1)'(link_in);
                r4       = sum_c[SLICE_W-1:0];
                link_out = sum_c[SLICE_W];
            end
            OP_SUB: begin
                sum_c    = {1'b0, a4} + {1'b0, ~b4} + (SLICE_W+1)'(link_in);
                r4       = sum_c[SLICE_W-1:0];
                link_out = sum_c[SLICE_W];
            end
            OP_AND: r4 = a4 & b4;
            OP_OR:  r4 = a4 | b4;
            OP_XOR: r4 = a4 ^ b4;
            OP_SHL: begin
                r4       = {a4[SLICE_W-2:0], link_in};
                link_out = a4[SLICE_W-1];
            end
            OP_SHR: begin
                r4       = {link_in, a4[SLICE_W-1:1]};
                link_out = a4[0];
            end
            OP_NOT: r4 = ~a4;
            default: r4 = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Nibble-serial ALU: one 4-bit slice per cycle, result published in DONE.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned NIBBLES = WIDTH / 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    input  logic             carry_in,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             n_carry_out,
    output logic             zero,
    output logic             bad_op
);

    localparam int unsigned IDX_W  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int unsigned BASE_W = IDX_W + 2;

    // Reject illegal widths at elaboration.
    if ((WIDTH % 4) != 0 || WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH || NIBBLES != WIDTH / 4) begin : g_width_check
        $error("alu_seq: illegal WIDTH %0d / NIBBLES %0d", WIDTH, NIBBLES);
    end

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               link_q, link_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               ncarry_q, ncarry_d;
    logic               zero_q, zero_d;
    logic               bad_q, bad_d;

    logic [IDX_W-1:0]   sel_c;
    logic [BASE_W-1:0]  base_c;
    logic [SLICE_W-1:0] a4_c, b4_c, r4_c;
    logic               link_out_c;

    // Slice selection: SHR walks MSB-first, everything else LSB-first.
    always_comb begin
        sel_c  = (op_q == OP_SHR) ? (IDX_W'(NIBBLES - 1) - idx_q) : idx_q;
        base_c = {sel_c, 2'b00};
        a4_c   = a_q[base_c +: SLICE_W];
        b4_c   = b_q[base_c +: SLICE_W];
    end

    alu_nibble u_nibble (
        .a4       (a4_c),
        .b4       (b4_c),
        .op       (op_q),
        .link_in  (link_q),
        .r4       (r4_c),
        .link_out (link_out_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        link_d   = link_q;
        acc_d    = acc_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        valid_d  = 1'b0;
        busy_d   = busy_q;
        ncarry_d = ncarry_q;
        zero_d   = zero_q;
        bad_d    = bad_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    link_d  = carry_in;
                    idx_d   = '0;
                    acc_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d[base_c +: SLICE_W] = r4_c;
                link_d = link_out_c;
                idx_d  = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(NIBBLES - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
                if (op_is_bad(op_q)) begin
                    result_d = '0;
                    ncarry_d = 1'b1;
                    zero_d   = 1'b1;
                    bad_d    = 1'b1;
                end else begin
                    result_d = acc_q;
                    ncarry_d = op_has_link(op_q) ? ~link_q : 1'b1;
                    zero_d   = (acc_q == '0);
                    bad_d    = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            link_q   <= 1'b0;
            acc_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            ncarry_q <= 1'b1;
            zero_q   <= 1'b1;
            bad_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            link_q   <= link_d;
            acc_q    <= acc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            ncarry_q <= ncarry_d;
            zero_q   <= zero_d;
            bad_q    <= bad_d;
        end
    end

    assign busy         = busy_q;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign n_carry_out  = ncarry_q;
    assign zero         = zero_q;
    assign bad_op       = bad_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH 8, 16 and 32.
module tb_alu_seq;
    import alu_pkg::*;

    typedef struct {
        logic [31:0] r;
        logic        nc;
        logic        z;
        logic        bad;
    } exp_t;

    logic clk = 1'b0;
    logic n_rst;

    logic        st8, ci8, busy8, rv8, nc8, z8, bad8;
    logic [7:0]  a8, b8, res8;
    logic [3:0]  op8;
    logic        st16, ci16, busy16, rv16, nc16, z16, bad16;
    logic [15:0] a16, b16, res16;
    logic [3:0]  op16;
    logic        st32, ci32, busy32, rv32, nc32, z32, bad32;
    logic [31:0] a32, b32, res32;
    logic [3:0]  op32;

    exp_t q8[$];
    exp_t q16[$];
    exp_t q32[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int vcnt8 = 0, vcnt16 = 0, vcnt32 = 0;
    int last32 = -1;
    logic stream_on = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .n_rst(n_rst), .start(st8), .a(a8), .b(b8), .op(op8), .carry_in(ci8),
        .busy(busy8), .result(res8), .result_valid(rv8), .n_carry_out(nc8), .zero(z8), .bad_op(bad8)
    );
    alu_seq #(.WIDTH(16)) u_dut16 (
        .clk(clk), .n_rst(n_rst), .start(st16), .a(a16), .b(b16), .op(op16), .carry_in(ci16),
        .busy(busy16), .result(res16), .result_valid(rv16), .n_carry_out(nc16), .zero(z16), .bad_op(bad16)
    );
    alu_seq #(.WIDTH(32)) u_dut32 (
        .clk(clk), .n_rst(n_rst), .start(st32), .a(a32), .b(b32), .op(op32), .carry_in(ci32),
        .busy(busy32), .result(res32), .result_valid(rv32), .n_carry_out(nc32), .zero(z32), .bad_op(bad32)
    );

    // Full-width reference model.
    function automatic exp_t model(input int unsigned w, input logic [3:0] o,
                                   input logic [31:0] av, input logic [31:0] bv, input logic c);
        exp_t e;
        logic [32:0] s;
        logic [31:0] mask, x, y;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        x = av & mask;
        y = bv & mask;
        s = '0;
        e.r = '0;
        e.nc = 1'b1;
        e.bad = 1'b0;
        case (o)
            OP_ADD: begin s = {1'b0, x} + {1'b0, y} + 33'(c); e.r = s[31:0] & mask; e.nc = ~s[w]; end
            OP_SUB: begin s = {1'b0, x} + {1'b0, ~y & mask} + 33'(c); e.r = s[31:0] & mask; e.nc = ~s[w]; end
            OP_AND: e.r = x & y;
            OP_OR:  e.r = x | y;
            OP_XOR: e.r = x ^ y;
            OP_SHL: begin e.r = ((x << 1) | 32'(c)) & mask; e.nc = ~x[w-1]; end
            OP_SHR: begin e.r = (x >> 1) | (32'(c) << (w - 1)); e.nc = ~x[0]; end
            OP_NOT: e.r = ~x & mask;
            default: e.bad = 1'b1;
        endcase
        e.z = (e.r == 32'd0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitors pop the scoreboard on each result_valid.
    always @(negedge clk) begin
        exp_t e;
        if (rv8 === 1'b1) begin
            vcnt8++;
            check("q8_entry", 32'(q8.size() != 0), 32'd1);
            if (q8.size() != 0) begin
                e = q8.pop_front();
                check("res8", 32'(res8), e.r);
                check("nc8", 32'(nc8), 32'(e.nc));
                check("zero8", 32'(z8), 32'(e.z));
                check("bad8", 32'(bad8), 32'(e.bad));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rv16 === 1'b1) begin
            vcnt16++;
            check("q16_entry", 32'(q16.size() != 0), 32'd1);
            if (q16.size() != 0) begin
                e = q16.pop_front();
                check("res16", 32'(res16), e.r);
                check("nc16", 32'(nc16), 32'(e.nc));
                check("zero16", 32'(z16), 32'(e.z));
                check("bad16", 32'(bad16), 32'(e.bad));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rv32 === 1'b1) begin
            vcnt32++;
            if (stream_on && last32 >= 0) check("rv32_period", 32'(cyc - last32), 32'd10);
            last32 = cyc;
            check("q32_entry", 32'(q32.size() != 0), 32'd1);
            if (q32.size() != 0) begin
                e = q32.pop_front();
                check("res32", res32, e.r);
                check("nc32", 32'(nc32), 32'(e.nc));
                check("zero32", 32'(z32), 32'(e.z));
                check("bad32", 32'(bad32), 32'(e.bad));
            end
        end
    end

    task automatic issue(input int w, input logic [3:0] o, input logic [31:0] av,
                         input logic [31:0] bv, input logic c);
        @(negedge clk);
        case (w)
            8:  begin op8 = o;  a8 = av[7:0];   b8 = bv[7:0];   ci8 = c;  st8 = 1'b1;  q8.push_back(model(8, o, av, bv, c)); end
            16: begin op16 = o; a16 = av[15:0]; b16 = bv[15:0]; ci16 = c; st16 = 1'b1; q16.push_back(model(16, o, av, bv, c)); end
            default: begin op32 = o; a32 = av; b32 = bv; ci32 = c; st32 = 1'b1; q32.push_back(model(32, o, av, bv, c)); end
        endcase
        @(posedge clk);
        #1;
        st8 = 1'b0;
        st16 = 1'b0;
        st32 = 1'b0;
    endtask

    // Cycles from the accepting edge until result_valid is seen.
    task automatic wait_valid(input int w, output int lat);
        logic found;
        found = 1'b0;
        lat = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if ((w == 8 && rv8 === 1'b1) || (w == 16 && rv16 === 1'b1) || (w == 32 && rv32 === 1'b1))
                found = 1'b1;
        end
        check($sformatf("rv%0d_seen", w), 32'(found), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int v0;
        exp_t e;
        n_rst = 1'b0;
        {st8, ci8, a8, b8, op8} = '0;
        {st16, ci16, a16, b16, op16} = '0;
        {st32, ci32, a32, b32, op32} = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_result", 32'(res16), 32'd0);
        check("rst_valid", 32'(rv16), 32'd0);
        check("rst_busy", 32'(busy16), 32'd0);
        check("rst_ncarry", 32'(nc16), 32'd1);
        check("rst_zero", 32'(z16), 32'd1);
        check("rst_bad", 32'(bad16), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;

        // ADD wrap to zero; operands scrambled while busy.
        issue(16, OP_ADD, 32'hFFFF, 32'h0001, 1'b0);
        check("add_busy", 32'(busy16), 32'd1);
        a16 = 16'h1234; b16 = 16'h5678; op16 = OP_XOR; ci16 = 1'b1;
        wait_valid(16, lat);
        check("add_latency", 32'(lat), 32'd5);
        check("add_busy_low", 32'(busy16), 32'd0);

        // SUB with borrow; result holds afterwards.
        issue(16, OP_SUB, 32'h1234, 32'h1235, 1'b1);
        wait_valid(16, lat);
        repeat (3) @(posedge clk);
        #1;
        check("sub_hold", 32'(res16), 32'h0000_FFFF);
        check("sub_pulse", 32'(rv16), 32'd0);

        // Reset during RUN aborts; first start after release accepted immediately.
        issue(16, OP_ADD, 32'h0AAA, 32'h1111, 1'b0);
        @(posedge clk);
        #3;
        n_rst = 1'b0;
        #1;
        check("abort_busy", 32'(busy16), 32'd0);
        check("abort_result", 32'(res16), 32'd0);
        check("abort_valid", 32'(rv16), 32'd0);
        q16.delete();
        v0 = vcnt16;
        @(negedge clk);
        n_rst = 1'b1;
        op16 = OP_ADD; a16 = 16'h0003; b16 = 16'h0004; ci16 = 1'b0; st16 = 1'b1;
        q16.push_back(model(16, OP_ADD, 32'h3, 32'h4, 1'b0));
        @(posedge clk);
        #1;
        st16 = 1'b0;
        check("post_rst_busy", 32'(busy16), 32'd1);
        wait_valid(16, lat);
        check("post_rst_latency", 32'(lat), 32'd5);
        @(negedge clk);
        #1;
        check("abort_no_pulse", 32'(vcnt16 - v0), 32'd1);
        check("post_rst_result", 32'(res16), 32'd7);

        // WIDTH=8 shifts.
        issue(8, OP_SHR, 32'h81, 32'h0, 1'b1);
        wait_valid(8, lat);
        check("shr8_latency", 32'(lat), 32'd3);
        issue(8, OP_SHL, 32'h81, 32'h0, 1'b0);
        wait_valid(8, lat);
        issue(8, OP_NOT, 32'hA5, 32'h0, 1'b0);
        wait_valid(8, lat);

        // Unsupported opcode; a start while busy is ignored.
        v0 = vcnt16;
        issue(16, 4'd9, 32'h1234, 32'h4321, 1'b0);
        @(negedge clk);
        st16 = 1'b1; op16 = OP_ADD; a16 = 16'h0001; b16 = 16'h0001;
        repeat (2) @(negedge clk);
        st16 = 1'b0;
        wait_valid(16, lat);
        repeat (10) @(posedge clk);
        #1;
        check("bad_single_pulse", 32'(vcnt16 - v0), 32'd1);
        check("bad_q_empty", 32'(q16.size()), 32'd0);

        // WIDTH=32 stream with start held high.
        stream_on = 1'b1;
        last32 = -1;
        v0 = vcnt32;
        @(negedge clk);
        op32 = 4'($urandom_range(0, 9)); a32 = $urandom; b32 = $urandom; ci32 = 1'($urandom_range(0, 1));
        q32.push_back(model(32, op32, a32, b32, ci32));
        st32 = 1'b1;
        @(posedge clk);
        for (int k = 1; k < 20; k++) begin
            #1;
            op32 = 4'($urandom_range(0, 9)); a32 = $urandom; b32 = $urandom; ci32 = 1'($urandom_range(0, 1));
            q32.push_back(model(32, op32, a32, b32, ci32));
            repeat (10) @(posedge clk);
        end
        #1;
        st32 = 1'b0;
        for (int i = 0; i < 200 && q32.size() != 0; i++) @(posedge clk);
        repeat (12) @(posedge clk);
        #1;
        check("stream_drained", 32'(q32.size()), 32'd0);
        check("stream_count", 32'(vcnt32 - v0), 32'd20);
        stream_on = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
